alu_exec_pipe: RTL and testbench
================================

ALU_EXEC_PIPE -- requirements
Module: alu_exec_pipe

Interface
REQ-001: Parameter WIDTH, default 16, operand and result width in bits.
REQ-002: Parameter TAGW, default 3, destination-register tag width in bits.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: flush  input  1  synchronous pipeline kill.
REQ-006: in_valid  input  1  issue request valid.
REQ-007: in_ready  output  1  pipe accepts an issue this cycle.
REQ-008: in_a  input  WIDTH  operand A.
REQ-009: in_b  input  WIDTH  operand B.
REQ-010: in_op  input  1  operation select: 0 = ADD, 1 = XOR.
REQ-011: in_rd  input  TAGW  destination tag, carried unchanged.
REQ-012: out_valid  output  1  result valid.
REQ-013: out_ready  input  1  consumer accepts the result.
REQ-014: out_result  output  WIDTH  registered result.
REQ-015: out_carry  output  1  ADD carry-out; 0 for XOR.
REQ-016: out_zero  output  1  high when out_result == 0.
REQ-017: out_rd  output  TAGW  tag of the presented result.
REQ-018: op_count  output  8  count of results retired.

Function
REQ-019: Two stages: S1 (operand register: a, b, op, rd, valid), then S2 (result register: result, carry, zero, rd, valid).
REQ-020: Issue accepted when in_valid && in_ready && !flush; S1 loads on the same edge.
REQ-021: S2 advance condition: s2_free = !s2_valid || out_ready.
REQ-022: S1 moves to S2 when s1_valid && s2_free; S2 computes from S1 contents on that edge.
REQ-023: in_ready = !flush && (!s1_valid || s2_free); combinational, no dependence on in_valid.
REQ-024: Latency: an accept at edge N with no backpressure gives out_valid high after edge N+1; throughput one op per cycle.
REQ-025: ADD: {carry, result} = a + b at WIDTH+1 bits; the result wraps modulo 2^WIDTH.
REQ-026: XOR: result = a ^ b; carry = 0.
REQ-027: out_zero derives from the registered result only.
REQ-028: Retire occurs when out_valid && out_ready; op_count increments by 1 on retire and wraps 255 -> 0.
REQ-029: While out_valid && !out_ready, all out_* signals hold stable; S1 holds and in_ready goes low only when S1 is also occupied.
REQ-030: A simultaneous retire and S1->S2 move in one cycle is a legal full-rate transfer; no bubble is inserted.
REQ-031: flush=1 clears s1_valid and s2_valid at the next edge.
REQ-032: flush has priority over accept, move and retire; no op_count increment in a flush cycle, even if out_ready=1.
REQ-033: Data registers need not clear on flush; only valids clear.
REQ-034: The pipe does not drop, duplicate or reorder issues; results retire in issue order.

Reset
REQ-035: rst_n low asynchronously clears s1_valid, s2_valid, op_count, out_result, out_carry and out_rd to 0.
REQ-036: During reset, out_zero reads 1 because out_result = 0.
REQ-037: While rst_n is low, in_ready = 1 and out_valid = 0.
REQ-038: Reset asserted mid-operation discards all in-flight ops with no retire.
REQ-039: The first accept is possible on the first rising edge after rst_n deasserts.

Verification
REQ-040: Streaming ADD. Stimulus: issue a=0xFFFF, b=0x0001, op=0, rd=5 with out_ready=1. Response: two edges later out_result=0x0000, out_carry=1, out_zero=1, out_rd=5, and op_count becomes 1.
REQ-041: XOR. Stimulus: a=0xA5A5, b=0x0F0F, op=1. Response: out_result=0xAAAA, out_carry=0, out_zero=0.
REQ-042: Backpressure. Stimulus: issue 3 back-to-back ops (tags 1, 2, 3) with out_ready=0. Response: in_ready drops after the 2nd accept; outputs hold on tag 1; after out_ready rises, tags 1, 2, 3 retire on consecutive cycles.
REQ-043: Flush. Stimulus: flush with both stages full and in_valid=1, out_ready=1. Response: next cycle out_valid=0, no accept, op_count unchanged.
REQ-044: Counter wrap. Stimulus: 256 retires. Response: op_count returns to 0.
REQ-045: Async reset. Stimulus: rst_n pulsed low between edges while ops are in flight. Response: out_valid=0 immediately, op_count=0, no later retire of the old ops.

Source files
------------

// File: rtl/alu_exec_pipe.sv
// Two-stage ADD/XOR execution pipe: operand register (S1) feeding a result
// register (S2), valid/ready handshake on both ends, synchronous flush.
module alu_exec_pipe #(
  parameter int WIDTH = 16,
  parameter int TAGW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  input  logic [TAGW-1:0]  in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic [TAGW-1:0]  out_rd,
  output logic [7:0]       op_count
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_op;
  logic [TAGW-1:0]  s1_rd;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_carry;
  logic [TAGW-1:0]  s2_rd;

  logic             s2_free;
  logic             accept;
  logic             move;
  logic             retire;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  // flush gates every transfer so nothing moves or retires in a kill cycle
  assign s2_free  = !s2_valid || out_ready;
  assign in_ready = !flush && (!s1_valid || s2_free);
  assign accept   = in_valid && in_ready;
  assign move     = !flush && s1_valid && s2_free;
  assign retire   = !flush && s2_valid && out_ready;

  always_comb begin
    sum        = {1'b0, s1_a} + {1'b0, s1_b};
    alu_result = sum[WIDTH-1:0];
    alu_carry  = sum[WIDTH];
    if (s1_op) begin
      alu_result = s1_a ^ s1_b;
      alu_carry  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= 1'b0;
      s1_rd    <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_op    <= in_op;
      s1_rd    <= in_rd;
    end else if (move) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_carry  <= 1'b0;
      s2_rd     <= '0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (move) begin
      s2_valid  <= 1'b1;
      s2_result <= alu_result;
      s2_carry  <= alu_carry;
      s2_rd     <= s1_rd;
    end else if (retire) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= 8'd0;
    end else if (retire) begin
      op_count <= op_count + 8'd1;
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_carry  = s2_carry;
  assign out_zero   = (s2_result == '0);
  assign out_rd     = s2_rd;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed bench for alu_exec_pipe: streaming, backpressure, flush, async
// reset and op_count wrap, with hand-computed expectations.
module tb_alu_exec_pipe;

  localparam int WIDTH = 16;
  localparam int TAGW  = 3;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_op;
  logic [TAGW-1:0]  in_rd;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_zero;
  logic [TAGW-1:0]  out_rd;
  logic [7:0]       op_count;

  int n_tests;
  int n_fail;

  alu_exec_pipe #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_rd     (out_rd),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic op,
                       input logic [2:0] rd);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_rd    = rd;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = 1'b0;
    in_rd     = '0;
    out_ready = 1'b0;

    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_zero", out_zero, 1);
    chk("rst_out_result", out_result, 0);
    chk("rst_op_count", op_count, 0);
    #9 rst_n = 1'b1;

    // streaming ADD with carry wrap
    out_ready = 1'b1;
    issue(16'hFFFF, 16'h0001, 1'b0, 3'd5);
    cyc();
    in_valid = 1'b0;
    chk("add_lat_not_yet", out_valid, 0);
    cyc();
    chk("add_valid", out_valid, 1);
    chk("add_result", out_result, 16'h0000);
    chk("add_carry", out_carry, 1);
    chk("add_zero", out_zero, 1);
    chk("add_rd", out_rd, 5);
    chk("add_cnt_pre", op_count, 0);
    cyc();
    chk("add_cnt", op_count, 1);
    chk("add_retired", out_valid, 0);

    // XOR then ADD back-to-back at full rate
    issue(16'hA5A5, 16'h0F0F, 1'b1, 3'd2);
    cyc();
    issue(16'h1234, 16'h1111, 1'b0, 3'd7);
    cyc();
    in_valid = 1'b0;
    chk("xor_result", out_result, 16'hAAAA);
    chk("xor_carry", out_carry, 0);
    chk("xor_zero", out_zero, 0);
    chk("xor_rd", out_rd, 2);
    cyc();
    chk("add2_valid", out_valid, 1);
    chk("add2_result", out_result, 16'h2345);
    chk("add2_carry", out_carry, 0);
    chk("add2_rd", out_rd, 7);
    chk("add2_cnt_mid", op_count, 2);
    cyc();
    chk("add2_cnt", op_count, 3);
    chk("add2_empty", out_valid, 0);

    // backpressure: tags 1,2,3
    out_ready = 1'b0;
    issue(16'd1, 16'd1, 1'b0, 3'd1);
    #1 chk("bp_ready0", in_ready, 1);
    cyc();
    issue(16'd2, 16'd2, 1'b0, 3'd2);
    #1 chk("bp_ready1", in_ready, 1);
    cyc();
    issue(16'd3, 16'd3, 1'b0, 3'd3);
    #1 chk("bp_ready_drop", in_ready, 0);
    cyc();
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_rd", out_rd, 1);
    chk("bp_hold_result", out_result, 2);
    chk("bp_still_stalled", in_ready, 0);
    cyc();
    chk("bp_hold_rd2", out_rd, 1);
    chk("bp_hold_cnt", op_count, 3);
    out_ready = 1'b1;
    #1 chk("bp_ready_rise", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    chk("bp_t2_rd", out_rd, 2);
    chk("bp_t2_result", out_result, 4);
    chk("bp_cnt4", op_count, 4);
    cyc();
    chk("bp_t3_rd", out_rd, 3);
    chk("bp_t3_result", out_result, 6);
    chk("bp_cnt5", op_count, 5);
    cyc();
    chk("bp_cnt6", op_count, 6);
    chk("bp_empty", out_valid, 0);

    // flush with both stages full
    out_ready = 1'b0;
    issue(16'd10, 16'd0, 1'b0, 3'd4);
    cyc();
    issue(16'd20, 16'd0, 1'b0, 3'd5);
    cyc();
    chk("fl_full_valid", out_valid, 1);
    issue(16'd30, 16'd0, 1'b0, 3'd6);
    out_ready = 1'b1;
    flush     = 1'b1;
    #1 chk("fl_in_ready", in_ready, 0);
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_cnt", op_count, 6);
    cyc();
    chk("fl_no_accept", out_valid, 0);
    cyc();
    chk("fl_cnt_after", op_count, 6);

    // async reset with ops in flight
    out_ready = 1'b0;
    issue(16'd1, 16'd2, 1'b0, 3'd1);
    cyc();
    issue(16'd3, 16'd4, 1'b0, 3'd2);
    cyc();
    in_valid = 1'b0;
    chk("ar_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_op_count", op_count, 0);
    chk("ar_out_zero", out_zero, 1);
    chk("ar_in_ready", in_ready, 1);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
    cyc();
    chk("ar_no_retire_valid", out_valid, 0);
    chk("ar_no_retire_cnt", op_count, 0);

    // 256 retires wrap op_count back to 0
    for (int i = 0; i < 256; i++) begin
      issue(i[15:0], 16'd1, 1'b0, i[2:0]);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    chk("wrap_255", op_count, 255);
    chk("wrap_last_valid", out_valid, 1);
    chk("wrap_last_result", out_result, 16'd256);
    chk("wrap_last_rd", out_rd, 3'd7);
    cyc();
    chk("wrap_zero", op_count, 0);
    chk("wrap_empty", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
